// File: rtl/fft_ram_block.sv
// fft_ram_block
// Ping-pong working memory for the FFT datapath. Two banks (A and B) of
// `size` x `width` words. Both write ports go to one bank and both read
// ports come from the other bank, so a butterfly stage reads from one bank
// and writes its results to the other. Toggling ram_select swaps the roles.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (output registers only)
//   wr_en       write enable for both write ports
//   ram_select  0: write A / read B, 1: write B / read A
//   addr_0/1    per-port address, shared by that port's read and write
//   data_0_in   port-0 write data
//   data_1_in   port-1 write data
//   data_0_out  port-0 read data (read bank at addr_0)
//   data_1_out  port-1 read data (read bank at addr_1)
//
// Build option:
//   FFT_RAM_OUTREG_EN  defined: reads are registered (1-cycle latency,
//                      outputs reset to 0). Undefined: combinational reads,
//                      reset has no effect on the outputs.
//
// If both write ports hit the same address, port 1's data is stored.

module fft_ram_block #(
    parameter int width = 64,
    parameter int size  = 1024,
    parameter int log_s = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             ram_select,
    input  logic [log_s-1:0] addr_0,
    input  logic [log_s-1:0] addr_1,
    input  logic [width-1:0] data_0_in,
    input  logic [width-1:0] data_1_in,
    output logic [width-1:0] data_0_out,
    output logic [width-1:0] data_1_out
);

    logic [width-1:0] bank_a [size];
    logic [width-1:0] bank_b [size];

    logic [width-1:0] rd_0;
    logic [width-1:0] rd_1;

    // Contents are deliberately not reset. Port 1 is assigned last so it
    // wins an address collision.
    always_ff @(posedge clk) begin
        if (wr_en && !ram_select) begin
            bank_a[addr_0] <= data_0_in;
            bank_a[addr_1] <= data_1_in;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && ram_select) begin
            bank_b[addr_0] <= data_0_in;
            bank_b[addr_1] <= data_1_in;
        end
    end

    // Read bank is always the one not being written.
    assign rd_0 = ram_select ? bank_a[addr_0] : bank_b[addr_0];
    assign rd_1 = ram_select ? bank_a[addr_1] : bank_b[addr_1];

`ifdef FFT_RAM_OUTREG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_0_out <= '0;
            data_1_out <= '0;
        end else begin
            data_0_out <= rd_0;
            data_1_out <= rd_1;
        end
    end
`else
    // Reset only matters for the registered variant.
    logic rst_unused;
    assign rst_unused = rst_n;

    assign data_0_out = rd_0;
    assign data_1_out = rd_1;
`endif

endmodule

// File: tb/tb_fft_ram_block.sv
module tb_fft_ram_block;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        ram_select;
    logic [9:0]  addr_0;
    logic [9:0]  addr_1;
    logic [63:0] data_0_in;
    logic [63:0] data_1_in;
    logic [63:0] data_0_out;
    logic [63:0] data_1_out;

    int errors = 0;
    int checks = 0;

    // Reference model: bank index 0 = A, 1 = B, with written flags since
    // contents are undefined until written.
    logic [63:0] mdl [2][1024];
    bit          vld [2][1024];

    logic [63:0] cap_0;
    logic [63:0] cap_1;

    fft_ram_block dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .ram_select (ram_select),
        .addr_0     (addr_0),
        .addr_1     (addr_1),
        .data_0_in  (data_0_in),
        .data_1_in  (data_1_in),
        .data_0_out (data_0_out),
        .data_1_out (data_1_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    // dN is driven to the DUT, mN is what the model stores on a write.
    task automatic cycle(input bit we, input bit sel,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] m0, input logic [63:0] m1,
                         input string tag);
        int rb;
        int wb;
        bit v0, v1;
        logic [63:0] e0, e1;
        wr_en = we; ram_select = sel;
        addr_0 = a0; addr_1 = a1;
        data_0_in = d0; data_1_in = d1;
        rb = sel ? 0 : 1;
        wb = sel ? 1 : 0;
        v0 = vld[rb][a0]; e0 = mdl[rb][a0];
        v1 = vld[rb][a1]; e1 = mdl[rb][a1];
        #1;
`ifndef FFT_RAM_OUTREG_EN
        if (v0) chk({tag, "_p0"}, data_0_out, e0);
        if (v1) chk({tag, "_p1"}, data_1_out, e1);
`endif
        @(posedge clk);
        if (we) begin
            mdl[wb][a0] = m0; vld[wb][a0] = 1'b1;
            mdl[wb][a1] = m1; vld[wb][a1] = 1'b1;
        end
        @(negedge clk);
`ifdef FFT_RAM_OUTREG_EN
        if (v0) chk({tag, "_p0"}, data_0_out, e0);
        if (v1) chk({tag, "_p1"}, data_1_out, e1);
`endif
    endtask

    task automatic wr(input bit sel, input logic [9:0] a0, input logic [9:0] a1,
                      input logic [63:0] d0, input logic [63:0] d1, input string tag);
        cycle(1'b1, sel, a0, a1, d0, d1, d0, d1, tag);
    endtask

    task automatic rd(input bit sel, input logic [9:0] a0, input logic [9:0] a1, input string tag);
        cycle(1'b0, sel, a0, a1, 64'h0, 64'h0, 64'h0, 64'h0, tag);
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; ram_select = 1'b0;
        addr_0 = '0; addr_1 = '0; data_0_in = '0; data_1_in = '0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 1024; i++) begin
                vld[b][i] = 1'b0; mdl[b][i] = '0;
            end
        repeat (3) @(negedge clk);
`ifdef FFT_RAM_OUTREG_EN
        chk("rst_p0", data_0_out, 64'h0);
        chk("rst_p1", data_1_out, 64'h0);
`endif
        rst_n = 1'b1;

        // Fill bank A
        for (int i = 0; i < 512; i++)
            wr(1'b0, 10'(i), 10'(i + 512), 64'(2 * i), 64'(i), "fill");
        for (int i = 0; i < 512; i++)
            rd(1'b1, 10'(i), 10'(i + 512), "fill_rd");
        // Explicit spot check with a literal expectation
        rd(1'b1, 10'd3, 10'd515, "spot");
        chk("spot_a3", data_0_out, 64'd6);
        chk("spot_a515", data_1_out, 64'd3);

        // Ping-pong copy A -> B through the outputs
        for (int i = 0; i < 512; i++) begin
            rd(1'b1, 10'(i), 10'(i + 512), "copy_rd");
            cap_0 = data_0_out;
            cap_1 = data_1_out;
            cycle(1'b1, 1'b1, 10'(i), 10'(i + 512), cap_0, cap_1,
                  mdl[0][i], mdl[0][i + 512], "copy_wr");
        end
        for (int i = 0; i < 512; i++)
            rd(1'b0, 10'(i), 10'(i + 512), "copy_b");
        for (int i = 0; i < 512; i += 37)
            rd(1'b1, 10'(i), 10'(i + 512), "a_kept");

        // Write inhibit
        cycle(1'b0, 1'b0, 10'd5, 10'd5, 64'hDEAD, 64'hDEAD, 64'hDEAD, 64'hDEAD, "inh");
        rd(1'b1, 10'd5, 10'd5, "inh_rd");
        chk("inh_a5", data_0_out, 64'd10);

        // Collision
        wr(1'b0, 10'd7, 10'd7, 64'h11, 64'h22, "col");
        rd(1'b1, 10'd7, 10'd7, "col_rd");
        chk("col_a7", data_0_out, 64'h22);
        chk("col_a7_p1", data_1_out, 64'h22);

        // Reset mid-stream
        rd(1'b1, 10'd100, 10'd600, "pre_rst");
        rst_n = 1'b0;
`ifdef FFT_RAM_OUTREG_EN
        #1;
        chk("mid_rst_p0", data_0_out, 64'h0);
        chk("mid_rst_p1", data_1_out, 64'h0);
        @(negedge clk);
        chk("hold_rst_p0", data_0_out, 64'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rel_p0", data_0_out, 64'h0);
        chk("post_rel_p1", data_1_out, 64'h0);
        @(negedge clk);
`else
        rd(1'b1, 10'd3, 10'd515, "rst_comb");
        rst_n = 1'b1;
`endif
        rd(1'b1, 10'd3, 10'd515, "after_rst");
        chk("after_rst_a3", data_0_out, 64'd6);

        // Isolation: write A with fresh data while reading B at same addresses
        for (int i = 0; i < 16; i++)
            wr(1'b0, 10'(i), 10'(i + 512), ~mdl[1][i], ~mdl[1][i + 512], "iso");

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [63:0] r0, r1;
            r0 = {$urandom, $urandom};
            r1 = {$urandom, $urandom};
            cycle(1'($urandom), 1'($urandom), 10'($urandom), 10'($urandom),
                  r0, r1, r0, r1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_ram_block.md
# fft_ram_block

Dual-bank, dual-port ping-pong working memory for the FFT datapath. Each bank holds `size` words of `width` bits. `ram_select` steers two simultaneous writes into one bank while two simultaneous reads come from the other bank. A butterfly stage can therefore read operands from one bank and write results to the other, and the roles swap between stages by toggling `ram_select`.

## Interface
Parameters:
- `width`, default 64: word width in bits (complex sample, re/im packed).
- `size`, default 1024: words per bank; must equal 2**`log_s`.
- `log_s`, default 10: address width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `wr_en`, in, 1: write enable for both write ports.
- `ram_select`, in, 1: bank steering.
  - 0: write bank A, read bank B.
  - 1: write bank B, read bank A.
- `addr_0`, in, `log_s`: port-0 address, shared by port-0 read and port-0 write.
- `addr_1`, in, `log_s`: port-1 address, shared by port-1 read and port-1 write.
- `data_0_in`, in, `width`: port-0 write data.
- `data_1_in`, in, `width`: port-1 write data.
- `data_0_out`, out, `width`: port-0 read data from the read bank at `addr_0`.
- `data_1_out`, out, `width`: port-1 read data from the read bank at `addr_1`.

## Operation
- Two banks, A and B, each `size` x `width`. Memory contents are not affected by reset; they are undefined until written.
- Write, when `wr_en`=1 at a rising edge:
  - `mem[wb][addr_0]` <= `data_0_in`.
  - `mem[wb][addr_1]` <= `data_1_in`.
  - `wb` is the write bank selected by `ram_select`.
- Write collision: if `addr_0`==`addr_1` with `wr_en`=1, port 1 wins. The stored word is `data_1_in`.
- `wr_en`=0: no bank is modified. Reads continue normally.
- Read: each port reads the read bank (the bank not selected for writing) at its own address, independently of `wr_en`.
- Reads and writes always target different banks. There is no read-during-write hazard, and the write data never appears on the outputs in the same cycle.
- `ram_select` may change every cycle. The bank roles follow the value sampled at each edge (registered read) or the current value (combinational read).

## Timing
- Write latency: data is stored at the rising edge where `wr_en`=1. It is readable once `ram_select` is toggled so that bank becomes the read bank.
- Read latency depends on `FFT_RAM_OUTREG_EN` (see Configuration).
- Reset:
  - With output registers, `data_0_out` and `data_1_out` = 0 while `rst_n`=0. They stay 0 until the first rising edge after `rst_n` deasserts.
  - Reset asserted mid-operation clears only the output registers. Bank contents are kept.
- Write path: no handshake; a write is always accepted in one cycle.

## Configuration
- `FFT_RAM_OUTREG_EN`:
  - Defined: registered reads with 1-cycle latency. The outputs at edge k+1 reflect the address and `ram_select` sampled at edge k. The output registers reset asynchronously to 0.
  - Undefined: combinational reads. The outputs follow `addr_*` and `ram_select` within the same cycle, and reset has no effect on the outputs.

## Test plan
- Fill bank A:
  - Stimulus: `ram_select`=0, `wr_en`=1, for i=0..511 write `addr_0`=i with i*2 and `addr_1`=i+512 with i.
  - Response: after toggling `ram_select`=1, reading i returns 2i and reading i+512 returns i on ports 0 and 1 respectively (1-cycle delayed if registered).
- Ping-pong copy:
  - Stimulus: with `ram_select`=1, feed `data_*_out` back into `data_*_in` at aligned addresses (accounting for read latency), then set `ram_select`=0.
  - Response: bank B reads back the same 2i / i pattern, and bank A is unchanged.
- Write inhibit:
  - Stimulus: `wr_en`=0 with writes of 0xDEAD to address 5.
  - Response: address 5 still reads its prior value (10).
- Collision:
  - Stimulus: `addr_0`=`addr_1`=7, `data_0_in`=0x11, `data_1_in`=0x22.
  - Response: address 7 reads 0x22.
- Reset:
  - Stimulus: assert `rst_n`=0 mid-stream (registered build), then release.
  - Response: outputs go to 0 immediately. After release, previously written data (e.g. address 3 = 6) reads back intact.
- Isolation:
  - Stimulus: write bank A while reading bank B at the same addresses.
  - Response: read data equals bank B contents, never the concurrent write data.
